// File: rtl/n_bits_seq_alu_pkg.sv
// Shared types and constants for the sequential ALU.
package nark_alu_pkg;

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpSub   = 3'b001,
        OpMul   = 3'b010,
        OpPassB = 3'b011,
        OpDiv   = 3'b100,
        OpMod   = 3'b101,
        OpRsv6  = 3'b110,
        OpRsv7  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } alu_state_t;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/n_bits_seq_alu_if.sv
// Request/response bundle of the sequential ALU.
interface n_bits_seq_alu_if #(
    parameter int unsigned BITS = 24
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic            CIN;
    logic [2:0]      OP;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [BITS-1:0] RST;
    logic            COUT;
    logic [3:0]      FLAGS;
    logic            ERR;

    modport master (
        output IN_VALID, A, B, CIN, OP, OUT_READY,
        input  IN_READY, OUT_VALID, RST, COUT, FLAGS, ERR
    );

    modport slave (
        input  IN_VALID, A, B, CIN, OP, OUT_READY,
        output IN_READY, OUT_VALID, RST, COUT, FLAGS, ERR
    );
endinterface

// File: rtl/n_bits_seq_alu_mul_div.sv
// Iterative shift unit shared by MUL (shift-add) and DIV/MOD (restoring).
// lo/hi hold product low/high halves, or quotient/remainder.
// Divide path only present when ALU_DIV_EN is defined.
module seq_mul_div_unit #(
    parameter int unsigned BITS = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef ALU_DIV_EN
    input  logic            is_div,
`endif
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            done,
    output logic [BITS-1:0] lo,
    output logic [BITS-1:0] hi
);
    localparam int unsigned CNT_W = $clog2(BITS + 1);

    logic [BITS-1:0]  acc_q, acc_d;
    logic [BITS-1:0]  mq_q, mq_d;
    logic [BITS-1:0]  b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS:0]    sum;
`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [BITS:0]    shifted;
`endif

    assign done = (cnt_q == CNT_W'(BITS));
    assign lo   = mq_q;
    assign hi   = acc_q;

    // One shift/add or shift/subtract step per cycle until BITS steps are done.
    always_comb begin
        acc_d = acc_q;
        mq_d  = mq_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
`ifdef ALU_DIV_EN
        div_d   = div_q;
        shifted = {acc_q, mq_q[BITS-1]};
`endif
        if (start) begin
            acc_d = '0;
            mq_d  = a;
            b_d   = b;
            cnt_d = '0;
`ifdef ALU_DIV_EN
            div_d = is_div;
`endif
        end else if (!done) begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_DIV_EN
            if (div_q) begin
                // Divisor of zero always "fits": quotient all ones, remainder = A.
                if (shifted >= {1'b0, b_q}) begin
                    acc_d = shifted[BITS-1:0] - b_q;
                    mq_d  = {mq_q[BITS-2:0], 1'b1};
                end else begin
                    acc_d = shifted[BITS-1:0];
                    mq_d  = {mq_q[BITS-2:0], 1'b0};
                end
            end else begin
                acc_d = sum[BITS:1];
                mq_d  = {sum[0], mq_q[BITS-1:1]};
            end
`else
            acc_d = sum[BITS:1];
            mq_d  = {sum[0], mq_q[BITS-1:1]};
`endif
        end
    end

    // Datapath registers; counter parks at BITS so the unit idles as done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            mq_q  <= '0;
            b_q   <= '0;
            cnt_q <= CNT_W'(BITS);
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/n_bits_seq_alu.sv
// Multi-cycle ALU: IDLE/CALC/DONE handshake FSM, add/sub path, flag logic.
// ALU_DIV_EN enables DIV/MOD; otherwise they complete as reserved ops.
module n_bits_seq_alu
    import nark_alu_pkg::*;
#(
    parameter int unsigned BITS = 24
) (
    input logic             CLK,
    input logic             NRST,
    n_bits_seq_alu_if.slave bus
);
    alu_state_t      state_q, state_d;
    alu_op_t         op_q;
    logic [BITS-1:0] a_q, b_q;
    logic            cin_q;
    logic            step_q;
    logic [BITS-1:0] rst_q, res;
    logic [3:0]      flags_q, flags;
    logic            cout_q, cout, err_q, err;

    logic            accept, iter_op, calc_done, unit_done;
    logic [BITS-1:0] unit_lo, unit_hi, b_eff;
    logic [BITS:0]   sum;

    assign accept        = bus.IN_VALID && (state_q == StIdle);
    assign bus.IN_READY  = (state_q == StIdle);
    assign bus.OUT_VALID = (state_q == StDone);
    assign bus.RST       = rst_q;
    assign bus.FLAGS     = flags_q;
    assign bus.COUT      = cout_q;
    assign bus.ERR       = err_q;

    seq_mul_div_unit #(
        .BITS (BITS)
    ) u_mul_div (
        .clk    (CLK),
        .rst_n  (NRST),
        .start  (accept),
`ifdef ALU_DIV_EN
        .is_div (bus.OP[2]),
`endif
        .a      (bus.A),
        .b      (bus.B),
        .done   (unit_done),
        .lo     (unit_lo),
        .hi     (unit_hi)
    );

`ifdef ALU_DIV_EN
    assign iter_op = (op_q == OpMul) || (op_q == OpDiv) || (op_q == OpMod);
`else
    assign iter_op = (op_q == OpMul);
`endif
    // Single-cycle ops spend one step in CALC so latency matches the iterative path.
    assign calc_done = iter_op ? unit_done : step_q;

    // Next-state logic for the handshake FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.IN_VALID) state_d = StCalc;
            StCalc:  if (calc_done) state_d = StDone;
            StDone:  if (bus.OUT_READY) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result and flag selection from the latched operation.
    always_comb begin
        b_eff = (op_q == OpSub) ? ~b_q : b_q;
        sum   = {1'b0, a_q} + {1'b0, b_eff} + {{BITS{1'b0}}, cin_q};
        res   = '0;
        flags = '0;
        cout  = 1'b0;
        err   = 1'b0;
        case (op_q)
            OpAdd, OpSub: begin
                res           = sum[BITS-1:0];
                cout          = sum[BITS];
                flags[FLAG_C] = sum[BITS];
                flags[FLAG_V] = (a_q[BITS-1] == b_eff[BITS-1]) &&
                                (sum[BITS-1] != a_q[BITS-1]);
            end
            OpMul: begin
                res           = unit_lo;
                flags[FLAG_C] = |unit_hi;
            end
            OpPassB: res = b_q;
`ifdef ALU_DIV_EN
            OpDiv: begin
                res           = unit_lo;
                flags[FLAG_V] = (b_q == '0);
            end
            OpMod: begin
                res           = unit_hi;
                flags[FLAG_V] = (b_q == '0);
            end
`endif
            default: err = 1'b1;
        endcase
        flags[FLAG_N] = res[BITS-1];
        flags[FLAG_Z] = (res == '0);
    end

    // State, operand latches and held result registers.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            step_q  <= 1'b0;
            rst_q   <= '0;
            flags_q <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= alu_op_t'(bus.OP);
                a_q    <= bus.A;
                b_q    <= bus.B;
                cin_q  <= bus.CIN;
                step_q <= 1'b0;
            end else if (state_q == StCalc) begin
                step_q <= 1'b1;
            end
            if ((state_q == StCalc) && calc_done) begin
                rst_q   <= res;
                flags_q <= flags;
                cout_q  <= cout;
                err_q   <= err;
            end
        end
    end

endmodule

// File: tb/tb_n_bits_seq_alu.sv
// Scoreboard bench for n_bits_seq_alu (BITS=24); DIV/MOD expectations follow ALU_DIV_EN.
module tb_n_bits_seq_alu;
    localparam int unsigned BITS = 24;

    typedef struct {
        logic [23:0] rst;
        logic [3:0]  flags;
        logic        cout;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   rise_cyc = 0;
    logic pv = 1'b0;
    exp_t sb[$];

    n_bits_seq_alu_if #(.BITS(BITS)) bus ();

    n_bits_seq_alu #(.BITS(BITS)) dut (
        .CLK  (clk),
        .NRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: note OUT_VALID rise, compare on the cycle the consumer takes the result.
    always @(negedge clk) begin
        if (bus.OUT_VALID && !pv) rise_cyc = cyc;
        pv = bus.OUT_VALID;
        if (bus.OUT_VALID && bus.OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rst", 32'(bus.RST), 32'(e.rst));
                chk("flags", 32'(bus.FLAGS), 32'(e.flags));
                chk("cout", 32'(bus.COUT), 32'(e.cout));
                chk("err", 32'(bus.ERR), 32'(e.err));
                chk("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic cin, input logic [23:0] er, input logic [3:0] ef,
                        input logic ec, input logic ee, input int lat, input bit push);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        bus.OP = op;
        bus.A = a;
        bus.B = b;
        bus.CIN = cin;
        bus.IN_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.IN_READY && n < 500);
        if (!bus.IN_READY) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.IN_VALID = 1'b0;
            return;
        end
        if (push) begin
            e.rst = er; e.flags = ef; e.cout = ec; e.err = ee; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, "_rst"}, 32'(bus.RST), 32'd0);
        chk({tag, "_cout"}, 32'(bus.COUT), 32'd0);
        chk({tag, "_flags"}, 32'(bus.FLAGS), 32'd0);
        chk({tag, "_err"}, 32'(bus.ERR), 32'd0);
    endtask

    initial begin
        logic [23:0] held_rst;
        logic [3:0]  held_flags;
        int          n;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.CIN = 1'b0;
        bus.OP = 3'b000;
        #3;
        chk_reset_vals("por");
        #10;
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // op, A, B, CIN, RST, FLAGS{V,C,Z,N}, COUT, ERR, latency
        send(3'b000, 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 4'b1001, 1'b0, 1'b0, 2, 1);
        drain();
        send(3'b001, 24'h000005, 24'h000005, 1'b1, 24'h000000, 4'b0110, 1'b1, 1'b0, 2, 1);
        drain();
        send(3'b010, 24'h001000, 24'h001000, 1'b0, 24'h000000, 4'b0110, 1'b0, 1'b0, 25, 1);
        drain();
        send(3'b011, 24'h000001, 24'h8000AA, 1'b0, 24'h8000AA, 4'b0001, 1'b0, 1'b0, 2, 1);
        drain();
        send(3'b000, 24'hFFFFFF, 24'h000001, 1'b1, 24'h000001, 4'b0100, 1'b1, 1'b0, 2, 1);
        drain();
        send(3'b010, 24'h000123, 24'h000456, 1'b0, 24'h04EDC2, 4'b0000, 1'b0, 1'b0, 25, 1);
        drain();
        send(3'b110, 24'h000010, 24'h000020, 1'b0, 24'h000000, 4'b0010, 1'b0, 1'b1, 2, 1);
        drain();
        send(3'b001, 24'h000003, 24'h000005, 1'b1, 24'hFFFFFE, 4'b0001, 1'b0, 1'b0, 2, 1);
        drain();
`ifdef ALU_DIV_EN
        send(3'b100, 24'd100, 24'd7, 1'b0, 24'd14, 4'b0000, 1'b0, 1'b0, 25, 1);
        drain();
        send(3'b101, 24'd100, 24'd7, 1'b0, 24'd2, 4'b0000, 1'b0, 1'b0, 25, 1);
        drain();
        send(3'b100, 24'd9, 24'd0, 1'b0, 24'hFFFFFF, 4'b1001, 1'b0, 1'b0, 25, 1);
        drain();
        send(3'b101, 24'd9, 24'd0, 1'b0, 24'd9, 4'b1000, 1'b0, 1'b0, 25, 1);
        drain();
`else
        send(3'b100, 24'd100, 24'd7, 1'b0, 24'd0, 4'b0010, 1'b0, 1'b1, 2, 1);
        drain();
        send(3'b101, 24'd100, 24'd7, 1'b0, 24'd0, 4'b0010, 1'b0, 1'b1, 2, 1);
        drain();
`endif

        // Back-pressure: hold the result while a new request waits.
        bus.OUT_READY = 1'b0;
        send(3'b010, 24'd3, 24'd5, 1'b0, 24'd15, 4'b0000, 1'b0, 1'b0, 25, 1);
        n = 0;
        while (!bus.OUT_VALID && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", 32'(bus.OUT_VALID), 32'd1);
        held_rst = bus.RST;
        held_flags = bus.FLAGS;
        chk("hold_rst_value", 32'(held_rst), 32'd15);
        @(posedge clk);
        #1;
        bus.OP = 3'b000;
        bus.A = 24'd2;
        bus.B = 24'd3;
        bus.CIN = 1'b0;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(bus.IN_READY), 32'd0);
            chk("hold_valid_stable", 32'(bus.OUT_VALID), 32'd1);
            chk("hold_rst_stable", 32'(bus.RST), 32'(held_rst));
            chk("hold_flags_stable", 32'(bus.FLAGS), 32'(held_flags));
        end
        @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
        send(3'b000, 24'd2, 24'd3, 1'b0, 24'd5, 4'b0000, 1'b0, 1'b0, 2, 1);
        drain();

        // Reset in the middle of a multiply.
        send(3'b010, 24'h000123, 24'h000456, 1'b0, 24'h0, 4'b0000, 1'b0, 1'b0, 25, 0);
        repeat (9) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk_reset_vals("midmul");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(bus.IN_READY), 32'd1);
        chk("post_reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        send(3'b000, 24'h000010, 24'h000020, 1'b1, 24'h000031, 4'b0000, 1'b0, 1'b0, 2, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
